// File: rtl/bldc_commutator.sv
// bldc_commutator: three-phase BLDC commutation (open loop -> hall closed loop), low-side PWM, hall fault.
// Optional dead time at sector changes when BLDC_DEADTIME_EN is defined.
module bldc_commutator #(
  parameter int PWM_BITS        = 8,
  parameter int PRESCALE        = 2700,
  parameter int OPEN_LOOP_TICKS = 90,
  parameter int WINDOW_TICKS    = 1024,
  parameter int MIN_EDGES       = 2,
  parameter int DEAD_CYCLES     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                dir,
  input  logic [PWM_BITS-1:0] duty,
  input  logic [2:0]          hall,
  output logic [2:0]          hin,
  output logic [2:0]          lin_n,
  output logic [2:0]          sector,
  output logic                closed_loop,
  output logic                hall_fault
);
  localparam int PW = $clog2(PRESCALE + 1);
  localparam int SW = $clog2(OPEN_LOOP_TICKS + 1);
  localparam int WW = $clog2(WINDOW_TICKS + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] STEP_MAX  = SW'(OPEN_LOOP_TICKS - 1);
  localparam logic [WW-1:0] WIN_MAX   = WW'(WINDOW_TICKS - 1);
  localparam logic [7:0]    MIN_E     = 8'(MIN_EDGES);
  // hall code -> sector, indexed by hall value 7..0
  localparam logic [7:0][2:0] FWD_TAB = {3'd0, 3'd1, 3'd3, 3'd2, 3'd5, 3'd0, 3'd4, 3'd0};
  localparam logic [7:0][2:0] REV_TAB = {3'd0, 3'd4, 3'd0, 3'd5, 3'd2, 3'd3, 3'd1, 3'd0};
  // phase masks {T,S,R} per sector 7..0
  localparam logic [7:0][2:0] HI_TAB  = {3'b000, 3'b000, 3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001};
  localparam logic [7:0][2:0] LO_TAB  = {3'b000, 3'b000, 3'b010, 3'b001, 3'b001, 3'b100, 3'b100, 3'b010};

  typedef enum logic [1:0] {IDLE, OPEN_LOOP, CLOSED_LOOP, FAULT} state_t;

  state_t              state, state_d;
  logic [2:0]          sector_d, hall_m, hall_s, hall_prev, hall_sec, next_sec;
  logic                fault_d, hall_edge, hall_bad, win_run, tick, step_end, win_end, enough, drive, low_on, dead;
  logic [PW-1:0]       presc_cnt;
  logic [SW-1:0]       step_cnt;
  logic [WW-1:0]       win_cnt;
  logic [7:0]          edge_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge clk or posedge rst)
    if (rst) {hall_m, hall_s, hall_prev} <= '0;
    else {hall_m, hall_s, hall_prev} <= {hall, hall_m, hall_s};

  assign hall_edge   = hall_s != hall_prev;
  assign hall_bad    = hall_s == 3'd0 || hall_s == 3'd7;
  assign win_run     = enable && (state == OPEN_LOOP || state == CLOSED_LOOP);
  assign tick        = presc_cnt == PRESC_MAX;
  assign step_end    = tick && step_cnt == STEP_MAX;
  assign win_end     = win_run && tick && win_cnt == WIN_MAX;
  assign enough      = edge_cnt >= MIN_E;
  assign hall_sec    = dir ? REV_TAB[hall_s] : FWD_TAB[hall_s];
  assign next_sec    = dir ? (sector == 3'd0 ? 3'd5 : sector - 3'd1) : (sector == 3'd5 ? 3'd0 : sector + 3'd1);
  assign closed_loop = state == CLOSED_LOOP;

  always_comb begin
    state_d  = state;
    sector_d = sector;
    fault_d  = hall_fault;
    if (!enable) begin
      state_d = IDLE;
      fault_d = 1'b0;
    end else
      case (state)
        IDLE: state_d = OPEN_LOOP;
        OPEN_LOOP: begin
          sector_d = step_end ? next_sec : sector;
          state_d  = (win_end && enough) ? CLOSED_LOOP : OPEN_LOOP;
        end
        CLOSED_LOOP: begin
          sector_d = hall_bad ? sector : hall_sec;
          fault_d  = hall_fault | hall_bad;
          state_d  = hall_bad ? FAULT : (win_end && !enough) ? OPEN_LOOP : CLOSED_LOOP;
        end
        default: state_d = FAULT;
      endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      sector     <= 3'd0;
      hall_fault <= 1'b0;
    end else begin
      state      <= state_d;
      sector     <= sector_d;
      hall_fault <= fault_d;
    end

  // an edge seen on the window-end cycle seeds the next window
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      step_cnt  <= '0;
      win_cnt   <= '0;
      edge_cnt  <= '0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      pwm_cnt   <= pwm_cnt + 1'b1;
      if (!enable || state != OPEN_LOOP) step_cnt <= '0;
      else if (tick) step_cnt <= step_end ? '0 : step_cnt + 1'b1;
      if (!win_run) begin
        win_cnt  <= '0;
        edge_cnt <= '0;
      end else begin
        if (tick) win_cnt <= win_end ? '0 : win_cnt + 1'b1;
        edge_cnt <= win_end ? {7'd0, hall_edge} : (hall_edge && edge_cnt != 8'hFF) ? edge_cnt + 8'd1 : edge_cnt;
      end
    end

`ifdef BLDC_DEADTIME_EN
  localparam int DW = DEAD_CYCLES > 0 ? $clog2(DEAD_CYCLES + 1) : 1;
  logic [DW-1:0] dead_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) dead_cnt <= '0;
    else dead_cnt <= (sector_d != sector) ? DW'(DEAD_CYCLES) : (dead_cnt != '0 ? dead_cnt - 1'b1 : dead_cnt);
  assign dead = dead_cnt != '0;
`else
  logic unused_dead;
  assign unused_dead = DEAD_CYCLES == 0;
  assign dead        = 1'b0;
`endif

  assign drive  = enable && !dead && (state == OPEN_LOOP || (state == CLOSED_LOOP && !hall_bad));
  assign low_on = pwm_cnt < duty;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hin   <= 3'b000;
      lin_n <= 3'b111;
    end else begin
      hin   <= drive ? HI_TAB[sector] : 3'b000;
      lin_n <= ~((drive && low_on) ? LO_TAB[sector] : 3'b000);
    end
endmodule

// File: doc/bldc_commutator.md
Name: bldc_commutator

Overview:
Parametrised three-phase BLDC commutation controller for the Tang Nano 9K brushless driver board; successor to the fixed-constant top-level commutation logic.
- Starts in open loop (timed sector stepping), switches to hall-sensor closed loop once hall edges are seen, and falls back when they stop.
- Direction select, programmable-resolution low-side PWM, hall fault detection, optional dead time.
- Drives the gate-driver HIN / active-low LIN pins directly.

Parameters:
PWM_BITS, 8, PWM counter/duty width; PWM period = 2^PWM_BITS clk cycles
PRESCALE, 2700, clk cycles per control tick (tick = one-cycle pulse when prescaler reaches PRESCALE-1)
OPEN_LOOP_TICKS, 90, ticks per sector step in open loop (>=1)
WINDOW_TICKS, 1024, ticks per hall-edge observation window
MIN_EDGES, 2, hall edges per window required to enter or stay in closed loop
DEAD_CYCLES, 4, clk cycles all switches are off at a sector change (used only with BLDC_DEADTIME_EN)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
enable  input  1  1 = drive motor; 0 = all switches off, state machine to IDLE
dir  input  1  0 = forward table, 1 = reverse table
duty  input  PWM_BITS  low-side on-time in clk cycles per PWM period
hall  input  3  raw hall sensors {C,B,A}, asynchronous
hin  output  3  high-side drive {T,S,R}, active-high
lin_n  output  3  low-side drive {T,S,R}, active-low
sector  output  3  current commutation sector, 0..5
closed_loop  output  1  1 while in CLOSED_LOOP state
hall_fault  output  1  sticky, set on invalid hall code 0 or 7 in CLOSED_LOOP

Behaviour:
- Reset values: hin=000, lin_n=111, sector=0, closed_loop=0, hall_fault=0, state IDLE, all counters 0.
- Hall input path: two-flop synchroniser, then a registered previous value. An edge is any change of the synchronised value.
- States:
  - IDLE: enable=1 -> OPEN_LOOP.
  - OPEN_LOOP: every OPEN_LOOP_TICKS ticks, sector steps +1 mod 6 (dir=0) or -1 mod 6 (dir=1); 5+1 wraps to 0, 0-1 wraps to 5. Step counter restarts on entry.
  - CLOSED_LOOP: sector is loaded each clk from the synchronised hall via the table for dir.
    - dir=0: 1->4, 2->0, 3->5, 4->2, 5->3, 6->1.
    - dir=1: 1->1, 2->3, 3->2, 4->5, 5->0, 6->4.
    - Hall code 0 or 7: sector holds, hall_fault <= 1, state -> FAULT.
  - FAULT: outputs off; exits only via rst, or via enable=0 which returns to IDLE and clears hall_fault.
- Window: counts ticks; edges are counted saturating at 255. At window end:
  - edges >= MIN_EDGES: OPEN_LOOP -> CLOSED_LOOP, or stay in CLOSED_LOOP.
  - otherwise: CLOSED_LOOP -> OPEN_LOOP.
  - Edge counter clears. An edge on the same cycle as window end counts toward the next window.
- enable=0 in any state: next cycle state IDLE, hin=000, lin_n=111, sector holds, window counters clear.
- Drive pattern, as (high phase, low phase) per sector: 0:(R,S), 1:(R,T), 2:(S,T), 3:(S,R), 4:(T,R), 5:(T,S).
  - The high phase is on continuously.
  - The low phase is on (lin_n bit=0) when pwm_cnt < duty.
  - All other bits are off.
- PWM: free-running PWM_BITS counter, wraps. duty=0 gives low side never on; duty=2^PWM_BITS-1 gives on 255/256 for the default width.
- Timing: outputs are registered, one clk after the sector/pwm_cnt update. Hall-to-sector latency is 3 clk (2 sync + 1 register).
- Invariant: hin[i]=1 and lin_n[i]=0 never occur together.

Optional Feature:
Macro BLDC_DEADTIME_EN.
- Defined: on any sector change, hin=000 and lin_n=111 for DEAD_CYCLES clk cycles, then the new pattern is applied. A further sector change during the dead interval restarts it.
- Undefined: the new pattern appears on the next clk and the DEAD_CYCLES parameter is unused.

Test Plan:
- Reset mid-run: assert rst asynchronously between clk edges -> hin=000, lin_n=111, sector=0, closed_loop=0 immediately, without waiting for a clk edge.
- Open loop, PRESCALE=4, OPEN_LOOP_TICKS=2, dir=0, hall static at 1 -> sector steps 0,1,2,3,4,5,0 every 8 clk. With dir=1 -> 0,5,4,...
- Closed-loop entry, WINDOW_TICKS=8, hall stepped 2->6->... several times per window -> closed_loop=1 after window end; dir=0 with hall=2 gives sector=0, hin=001, lin_n=101 gated by PWM. With hall frozen for a full window -> closed_loop=0.
- PWM, PWM_BITS=4, duty=5, sector 0 -> lin_n[1]=0 for exactly 5 of every 16 clk; duty=0 -> lin_n=111 always.
- Hall fault: in CLOSED_LOOP drive hall=7 -> hall_fault=1, outputs off, sector holds. enable=0 then 1 -> fault cleared, OPEN_LOOP.
- With BLDC_DEADTIME_EN, DEAD_CYCLES=3: sector change -> exactly 3 clk of hin=000/lin_n=111 before the new pattern. Shoot-through invariant is checked every cycle.
